// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM state type and flag policy for the ALU execute controller.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_PASSB = 4'b0000;
  localparam logic [3:0] OP_PASSA = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_INC   = 4'b0101;
  localparam logic [3:0] OP_DEC   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_COM   = 4'b1001;
  localparam logic [3:0] OP_SWAP  = 4'b1010;
  localparam logic [3:0] OP_CLR   = 4'b1011;
  localparam logic [3:0] OP_RLF   = 4'b1100;
  localparam logic [3:0] OP_BSF   = 4'b1101;
  localparam logic [3:0] OP_BCF   = 4'b1110;
  localparam logic [3:0] OP_RRF   = 4'b1111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  // Only arithmetic ops touch the carry flag; everything else leaves it alone.
  function automatic logic carry_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: carry_op = 1'b1;
      default:                        carry_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// File register array: asynchronous read, synchronous write, contents survive reset.
module alu_regfile #(
  parameter int REG_DEPTH = 16,
  parameter int ADDR_W    = $clog2(REG_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [REG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state execute controller: latches a command, fetches operand B, drives the
// external ALU and writes the result back to W or the file register.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int REG_DEPTH = 16,
  parameter int ADDR_W    = $clog2(REG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic              cmd_dest,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_bit,
  input  logic              cmd_lit_en,
  input  logic [7:0]        cmd_lit,
  output logic [3:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [2:0]        alu_bit,
  input  logic [7:0]        alu_ans,
  input  logic              alu_carry,
  output logic [7:0]        w_out,
  output logic              status_z,
  output logic              status_c,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic              dest_q, dest_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        bit_q, bit_d;
  logic              lit_en_q, lit_en_d;
  logic [7:0]        lit_q, lit_d;
  logic [7:0]        opb_q, opb_d;
  logic [7:0]        res_q, res_d;
  logic              cres_q, cres_d;
  logic [7:0]        w_q, w_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [7:0]        rf_rdata;
  logic              rf_we;

  alu_regfile #(.REG_DEPTH(REG_DEPTH), .ADDR_W(ADDR_W)) u_regfile (
    .clk   (clk),
    .we    (rf_we),
    .waddr (addr_q),
    .wdata (res_q),
    .raddr (addr_q),
    .rdata (rf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dest_d   = dest_q;
    addr_d   = addr_q;
    bit_d    = bit_q;
    lit_en_d = lit_en_q;
    lit_d    = lit_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cres_d   = cres_q;
    w_d      = w_q;
    z_d      = z_q;
    c_d      = c_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          dest_d   = cmd_dest;
          addr_d   = cmd_addr;
          bit_d    = cmd_bit;
          lit_en_d = cmd_lit_en;
          lit_d    = cmd_lit;
          state_d  = READ;
        end
      end
      READ: begin
        opb_d   = lit_en_q ? lit_q : rf_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_ans;
        cres_d  = alu_carry;
        state_d = WB;
      end
      WB: begin
        if (!dest_q) w_d = res_q;
        z_d = (res_q == 8'h00);
        if (carry_op(op_q)) c_d = cres_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously, so a WB interrupted by reset never writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dest_q   <= 1'b0;
      addr_q   <= '0;
      bit_q    <= '0;
      lit_en_q <= 1'b0;
      lit_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      cres_q   <= 1'b0;
      w_q      <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      addr_q   <= addr_d;
      bit_q    <= bit_d;
      lit_en_q <= lit_en_d;
      lit_q    <= lit_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      cres_q   <= cres_d;
      w_q      <= w_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  always_comb begin
    alu_op  = 4'b0000;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_bit = 3'b000;
    if (state_q == EXEC) begin
      alu_op  = op_q;
      alu_a   = w_q;
      alu_b   = opb_q;
      alu_bit = bit_q;
    end
  end

  assign rf_we     = (state_q == WB) && dest_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == WB);
  assign w_out     = w_q;
  assign status_z  = z_q;
  assign status_c  = c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU in the loop.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic       cmd_dest;
  logic [3:0] cmd_addr;
  logic [2:0] cmd_bit;
  logic       cmd_lit_en;
  logic [7:0] cmd_lit;
  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_bit;
  logic [7:0] alu_ans;
  logic       alu_carry;
  logic [7:0] w_out;
  logic       status_z;
  logic       status_c;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.REG_DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dest   (cmd_dest),
    .cmd_addr   (cmd_addr),
    .cmd_bit    (cmd_bit),
    .cmd_lit_en (cmd_lit_en),
    .cmd_lit    (cmd_lit),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_bit    (alu_bit),
    .alu_ans    (alu_ans),
    .alu_carry  (alu_carry),
    .w_out      (w_out),
    .status_z   (status_z),
    .status_c   (status_c),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural ALU; carry is forced low for ops that should not affect C.
  always_comb begin
    logic [8:0] sum;
    sum       = 9'h000;
    alu_ans   = alu_b;
    alu_carry = 1'b0;
    case (alu_op)
      4'b0001: alu_ans = alu_a;
      4'b0010: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_ans   = sum[7:0];
        alu_carry = sum[8];
      end
      4'b0011: begin
        alu_ans   = alu_a - alu_b;
        alu_carry = (alu_a >= alu_b);
      end
      4'b0101: begin
        sum       = {1'b0, alu_b} + 9'd1;
        alu_ans   = sum[7:0];
        alu_carry = sum[8];
      end
      4'b1101: alu_ans = alu_b | (8'h01 << alu_bit);
      4'b1110: alu_ans = alu_b & ~(8'h01 << alu_bit);
      default: alu_ans = alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic dest, input logic [3:0] addr,
                      input logic [2:0] bitn, input logic lit_en, input logic [7:0] lit);
    bit ok;
    ok         = 1'b0;
    cmd_op     = op;
    cmd_dest   = dest;
    cmd_addr   = addr;
    cmd_bit    = bitn;
    cmd_lit_en = lit_en;
    cmd_lit    = lit;
    cmd_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic dest, input logic [3:0] addr,
                         input logic [2:0] bitn, input logic lit_en, input logic [7:0] lit);
    send(op, dest, addr, bitn, lit_en, lit);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] rdy_seen;
    logic [7:0] done_seen;
    int dcnt;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 4'h0;
    cmd_dest   = 1'b0;
    cmd_addr   = 4'h0;
    cmd_bit    = 3'h0;
    cmd_lit_en = 1'b0;
    cmd_lit    = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_w", w_out, 8'h00);
    check("rst_z", status_z, 1'b0);
    check("rst_c", status_c, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_alu_op", alu_op, 4'h0);

    // Load W with a literal, then literal add with carry out
    run_cmd(4'h0, 1'b0, 4'h0, 3'h0, 1'b1, 8'h10);
    check("ld_w", w_out, 8'h10);
    send(4'h2, 1'b0, 4'h0, 3'h0, 1'b1, 8'hF5);
    check("add_busy", busy, 1'b1);
    check("add_done_t1", done, 1'b0);
    @(posedge clk); #1;
    check("add_alu_op", alu_op, 4'h2);
    check("add_alu_a", alu_a, 8'h10);
    check("add_alu_b", alu_b, 8'hF5);
    check("add_done_exec", done, 1'b0);
    @(posedge clk); #1;
    check("add_done_t2", done, 1'b1);
    check("add_alu_idle", alu_op, 4'h0);
    @(posedge clk); #1;
    check("add_w", w_out, 8'h05);
    check("add_c", status_c, 1'b1);
    check("add_z", status_z, 1'b0);
    check("add_done_t3", done, 1'b0);

    // Register subtract written back to the file
    run_cmd(4'h0, 1'b1, 4'h3, 3'h0, 1'b1, 8'h20);
    run_cmd(4'h0, 1'b0, 4'h0, 3'h0, 1'b1, 8'h20);
    run_cmd(4'h3, 1'b1, 4'h3, 3'h0, 1'b0, 8'h00);
    check("sub_w_kept", w_out, 8'h20);
    check("sub_z", status_z, 1'b1);
    check("sub_c", status_c, 1'b1);
    run_cmd(4'h0, 1'b0, 4'h3, 3'h0, 1'b0, 8'h00);
    check("sub_reg3", w_out, 8'h00);

    // Bit set / clear leave C alone
    run_cmd(4'h0, 1'b1, 4'h7, 3'h0, 1'b1, 8'h00);
    run_cmd(4'hD, 1'b1, 4'h7, 3'h6, 1'b0, 8'h00);
    check("bsf_z", status_z, 1'b0);
    check("bsf_c", status_c, 1'b1);
    run_cmd(4'h0, 1'b0, 4'h7, 3'h0, 1'b0, 8'h00);
    check("bsf_reg7", w_out, 8'h40);
    run_cmd(4'hE, 1'b1, 4'h7, 3'h6, 1'b0, 8'h00);
    check("bcf_z", status_z, 1'b1);
    check("bcf_c", status_c, 1'b1);
    run_cmd(4'h0, 1'b0, 4'h7, 3'h0, 1'b0, 8'h00);
    check("bcf_reg7", w_out, 8'h00);

    // Back-to-back with valid held high; second command reads the first's write
    cmd_op = 4'h0; cmd_dest = 1'b1; cmd_addr = 4'h9; cmd_lit_en = 1'b1; cmd_lit = 8'h5A;
    cmd_valid = 1'b1;
    rdy_seen  = '0;
    done_seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdy_seen[i]  = cmd_ready;
      done_seen[i] = done;
      @(posedge clk); #1;
      if (i == 0) begin
        cmd_dest = 1'b0; cmd_lit_en = 1'b0; cmd_lit = 8'h00;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_ready", rdy_seen, 8'h11);
    check("b2b_done", done_seen, 8'h88);
    check("b2b_w", w_out, 8'h5A);

    // Inputs wiggling while busy are ignored
    send(4'h2, 1'b0, 4'h0, 3'h0, 1'b1, 8'hA7);
    cmd_valid = 1'b1; cmd_op = 4'h3; cmd_lit = 8'hFF;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dcnt += int'(done);
      @(posedge clk); #1;
      if (i == 0) begin
        check("busy_alu_b", alu_b, 8'hA7);
        check("busy_alu_op", alu_op, 4'h2);
        cmd_valid = 1'b0; cmd_op = 4'h0;
      end else if (i == 1) begin
        cmd_valid = 1'b1; cmd_lit_en = 1'b0;
      end else if (i == 2) begin
        cmd_valid = 1'b0;
      end
    end
    check("busy_ndone", dcnt, 1);
    check("busy_w", w_out, 8'h01);
    check("busy_c", status_c, 1'b1);

    // Reset during EXEC aborts the pending register write
    send(4'h5, 1'b1, 4'h3, 3'h0, 1'b1, 8'h76);
    @(posedge clk); #1;
    check("rstx_alu_op", alu_op, 4'h5);
    reset_n = 1'b0;
    #2;
    check("rstx_busy", busy, 1'b0);
    check("rstx_w", w_out, 8'h00);
    check("rstx_z", status_z, 1'b0);
    check("rstx_c", status_c, 1'b0);
    check("rstx_done", done, 1'b0);
    check("rstx_alu_b", alu_b, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("rstx_ndone", dcnt, 0);
    run_cmd(4'h0, 1'b0, 4'h3, 3'h0, 1'b0, 8'h00);
    check("rstx_reg3", w_out, 8'h00);
    check("rstx_rd_z", status_z, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
